// File: rtl/eros_obi_rr_arbiter.sv
// Round-robin arbiter: NUM_REQ OBI managers share one downstream OBI port; responses return in order via an ID FIFO.
// Latency: zero-cycle request/grant and response pass-through (combinational); state updates on the next clk_i edge.
// Backpressure: an ungranted request locks the winner until granted; no new requests are issued once MAX_OUTSTANDING are in flight.
module eros_obi_rr_arbiter #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            mst_req_o,
  output logic                            mst_we_o,
  output logic [ADDR_WIDTH-1:0]           mst_addr_o,
  output logic [DATA_WIDTH/8-1:0]         mst_be_o,
  output logic [DATA_WIDTH-1:0]           mst_wdata_o,
  input  logic                            mst_gnt_i,
  input  logic                            mst_rvalid_i,
  input  logic [DATA_WIDTH-1:0]           mst_rdata_i,
  output logic                            busy_o,
  output logic                            protocol_err_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  // Registered state
  logic [IDX_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic             lock_vld_q,  lock_vld_d;
  logic [IDX_W-1:0] lock_idx_q,  lock_idx_d;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic             err_q,       err_d;

  // Combinational helpers
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic [IDX_W:0]   arb_sum;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             not_full;
  logic             hs;
  logic             pop;
  logic             spurious;
  logic             lock_drop;
  logic [IDX_W-1:0] head_idx;

  // Head/tail pointers wrap at MAX_OUTSTANDING, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign any_req   = |req_i;
  // No bypass when full: a pop this cycle only frees a slot for the next cycle.
  assign not_full  = (count_q < CNT_W'(MAX_OUTSTANDING));
  assign mst_req_o = any_req & not_full;
  // A locked address phase keeps its manager regardless of newer higher-priority requests.
  assign winner    = lock_vld_q ? lock_idx_q : arb_idx;
  assign hs        = mst_req_o & mst_gnt_i;
  // A response with nothing outstanding cannot be routed; it is flagged instead of popped,
  // even if a handshake in the same cycle is pushing a new entry.
  assign pop       = mst_rvalid_i & (count_q != '0);
  assign spurious  = mst_rvalid_i & (count_q == '0);
  assign lock_drop = lock_vld_q & ~req_i[lock_idx_q];
  assign head_idx  = fifo_q[rd_ptr_q];

  assign rdata_o        = mst_rdata_i;
  assign busy_o         = (count_q != '0);
  assign protocol_err_o = err_q;

  // Round-robin search: first requester at or after rr_ptr, modulo NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_sum   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
      if (arb_sum >= (IDX_W + 1)'(NUM_REQ)) begin
        arb_sum = arb_sum - (IDX_W + 1)'(NUM_REQ);
      end
      if (!arb_found && req_i[arb_sum[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_sum[IDX_W-1:0];
      end
    end
  end

  // Downstream address-phase mux, per-manager grant and response routing.
  always_comb begin
    mst_we_o    = 1'b0;
    mst_addr_o  = '0;
    mst_be_o    = '0;
    mst_wdata_o = '0;
    gnt_o       = '0;
    rvalid_o    = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (mst_req_o && (winner == IDX_W'(k))) begin
        mst_we_o    = we_i[k];
        mst_addr_o  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        mst_be_o    = be_i[k*BE_W +: BE_W];
        mst_wdata_o = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      gnt_o[k]    = hs  && (winner == IDX_W'(k));
      rvalid_o[k] = pop && (head_idx == IDX_W'(k));
    end
  end

  // Next-state: lock, round-robin pointer, ID FIFO, outstanding count and sticky error.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_idx_d = lock_idx_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_d      = err_q | spurious;

    // Lock: clear on handshake or when the locked manager withdraws; otherwise
    // capture the winner of an ungranted request so its address phase stays put.
    if (hs) begin
      lock_vld_d = 1'b0;
    end else if (lock_drop) begin
      lock_vld_d = 1'b0;
    end else if (mst_req_o && !mst_gnt_i) begin
      lock_vld_d = 1'b1;
      lock_idx_d = winner;
    end

    if (hs) begin
      rr_ptr_d         = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
      fifo_d[wr_ptr_q] = winner;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({hs, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset drops every in-flight transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      fifo_q     <= fifo_d;
    end
  end

endmodule

// File: tb/tb_eros_obi_rr_arbiter.sv
// Directed bench for eros_obi_rr_arbiter (NUM_REQ=2, MAX_OUTSTANDING=4).
// Expected response routing comes from a queue of manager IDs pushed at each expected grant.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_eros_obi_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_i;
  logic [1:0]  we_i;
  logic [63:0] addr_i;
  logic [7:0]  be_i;
  logic [63:0] wdata_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rvalid_o;
  logic [31:0] rdata_o;
  logic        mst_req_o;
  logic        mst_we_o;
  logic [31:0] mst_addr_o;
  logic [3:0]  mst_be_o;
  logic [31:0] mst_wdata_o;
  logic        mst_gnt_i;
  logic        mst_rvalid_i;
  logic [31:0] mst_rdata_i;
  logic        busy_o;
  logic        protocol_err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int sb[$];
  logic exp_err;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;

  eros_obi_rr_arbiter #(
    .NUM_REQ(2), .MAX_OUTSTANDING(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .mst_req_o(mst_req_o), .mst_we_o(mst_we_o), .mst_addr_o(mst_addr_o), .mst_be_o(mst_be_o),
    .mst_wdata_o(mst_wdata_o), .mst_gnt_i(mst_gnt_i), .mst_rvalid_i(mst_rvalid_i),
    .mst_rdata_i(mst_rdata_i), .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs and registered status, update model.
  task automatic step(input string tag, input logic [1:0] req, input logic g, input logic rv,
                      input logic [31:0] rd, input logic [1:0] egnt, input logic emreq,
                      input logic [31:0] eaddr);
    int e;
    logic [1:0] ev;
    @(negedge clk_i);
    req_i        = req;
    mst_gnt_i    = g;
    mst_rvalid_i = rv;
    mst_rdata_i  = rd;
    #1;
    chk({tag, ".busy"}, busy_o, (sb.size() != 0));
    chk({tag, ".err"},  protocol_err_o, exp_err);
    chk({tag, ".gnt"},  gnt_o, egnt);
    chk({tag, ".mreq"}, mst_req_o, emreq);
    chk({tag, ".addr"}, mst_addr_o, eaddr);
    if (rv) begin
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        ev = 2'b01 << e;
        chk({tag, ".rvalid"}, rvalid_o, ev);
        chk({tag, ".rdata"},  rdata_o, rd);
      end else begin
        chk({tag, ".rvalid_spur"}, rvalid_o, 2'b00);
        exp_err = 1'b1;
      end
    end else begin
      chk({tag, ".rvalid_idle"}, rvalid_o, 2'b00);
    end
    if (egnt == 2'b01) sb.push_back(0);
    else if (egnt == 2'b10) sb.push_back(1);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni       = 1'b0;
    req_i        = 2'b00;
    mst_gnt_i    = 1'b0;
    mst_rvalid_i = 1'b0;
    mst_rdata_i  = '0;
    sb.delete();
    exp_err      = 1'b0;
    #1;
    chk("rst.gnt",    gnt_o, 2'b00);
    chk("rst.rvalid", rvalid_o, 2'b00);
    chk("rst.mreq",   mst_req_o, 1'b0);
    chk("rst.busy",   busy_o, 1'b0);
    chk("rst.err",    protocol_err_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni       = 1'b0;
    req_i        = 2'b00;
    we_i         = 2'b10;
    addr_i       = {A1, A0};
    be_i         = {4'h3, 4'hF};
    wdata_i      = {32'h2222_2222, 32'h1111_1111};
    mst_gnt_i    = 1'b0;
    mst_rvalid_i = 1'b0;
    mst_rdata_i  = '0;
    exp_err      = 1'b0;

    // Single manager read, response two cycles after the handshake.
    do_reset();
    step("single.hs",   2'b01, 1, 0, 32'h0,         2'b01, 1, A0);
    chk("single.we", mst_we_o, 1'b0);
    step("single.wait", 2'b00, 0, 0, 32'h0,         2'b00, 0, 32'h0);
    step("single.rsp",  2'b00, 0, 1, 32'hDEAD_BEEF, 2'b00, 0, 32'h0);
    step("single.idle", 2'b00, 0, 0, 32'h0,         2'b00, 0, 32'h0);

    // Contention: both managers request every cycle, grants alternate from manager 0.
    do_reset();
    step("cont.g0", 2'b11, 1, 0, 32'h0, 2'b01, 1, A0);
    chk("cont.g0.wdata", mst_wdata_o, 32'h1111_1111);
    step("cont.g1", 2'b11, 1, 0, 32'h0, 2'b10, 1, A1);
    chk("cont.g1.we",    mst_we_o, 1'b1);
    chk("cont.g1.be",    mst_be_o, 4'h3);
    chk("cont.g1.wdata", mst_wdata_o, 32'h2222_2222);
    step("cont.g2", 2'b11, 1, 0, 32'h0, 2'b01, 1, A0);
    step("cont.g3", 2'b11, 1, 0, 32'h0, 2'b10, 1, A1);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("cont.r%0d", i), 2'b00, 0, 1, 32'hA000_0000 + i, 2'b00, 0, 32'h0);
    end

    // Lock: ungranted request from manager 0 is held even when manager 1 arrives.
    do_reset();
    step("lock.c1", 2'b01, 0, 0, 32'h0, 2'b00, 1, A0);
    step("lock.c2", 2'b11, 0, 0, 32'h0, 2'b00, 1, A0);
    step("lock.c3", 2'b11, 0, 0, 32'h0, 2'b00, 1, A0);
    step("lock.c4", 2'b11, 1, 0, 32'h0, 2'b01, 1, A0);
    step("lock.c5", 2'b11, 1, 0, 32'h0, 2'b10, 1, A1);
    step("lock.r0", 2'b00, 0, 1, 32'h0000_0C00, 2'b00, 0, 32'h0);
    step("lock.r1", 2'b00, 0, 1, 32'h0000_0C01, 2'b00, 0, 32'h0);

    // Full: four outstanding blocks the request; a pop reopens it one cycle later.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step($sformatf("full.hs%0d", i), 2'b01, 1, 0, 32'h0, 2'b01, 1, A0);
    end
    step("full.blk",  2'b01, 1, 0, 32'h0,         2'b00, 0, 32'h0);
    step("full.pop",  2'b01, 1, 1, 32'hF000_0000, 2'b00, 0, 32'h0);
    step("full.next", 2'b01, 1, 0, 32'h0,         2'b01, 1, A0);
    for (int i = 1; i < 5; i++) begin
      step($sformatf("full.r%0d", i), 2'b00, 0, 1, 32'hF000_0000 + i, 2'b00, 0, 32'h0);
    end

    // Simultaneous push and pop at count 2; pointers wrap.
    do_reset();
    step("pp.hs0", 2'b01, 1, 0, 32'h0,         2'b01, 1, A0);
    step("pp.hs1", 2'b10, 1, 0, 32'h0,         2'b10, 1, A1);
    step("pp.x0",  2'b01, 1, 1, 32'h5000_0000, 2'b01, 1, A0);
    step("pp.x1",  2'b10, 1, 1, 32'h5000_0001, 2'b10, 1, A1);
    step("pp.x2",  2'b01, 1, 1, 32'h5000_0002, 2'b01, 1, A0);
    step("pp.d0",  2'b00, 0, 1, 32'h5000_0003, 2'b00, 0, 32'h0);
    step("pp.d1",  2'b00, 0, 1, 32'h5000_0004, 2'b00, 0, 32'h0);
    step("pp.idle", 2'b00, 0, 0, 32'h0,        2'b00, 0, 32'h0);

    // Spurious response at idle: sticky error, cleared asynchronously by reset.
    do_reset();
    step("spur.rv",  2'b00, 0, 1, 32'h1234_5678, 2'b00, 0, 32'h0);
    step("spur.hold0", 2'b00, 0, 0, 32'h0,       2'b00, 0, 32'h0);
    step("spur.hold1", 2'b00, 0, 0, 32'h0,       2'b00, 0, 32'h0);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("spur.async_clr", protocol_err_o, 1'b0);
    exp_err = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Handshake and response together at count 0: response is spurious, push still happens.
    do_reset();
    step("hsrv.c0", 2'b01, 1, 1, 32'h7777_0000, 2'b01, 1, A0);
    step("hsrv.r",  2'b00, 0, 1, 32'h7777_0001, 2'b00, 0, 32'h0);
    step("hsrv.idle", 2'b00, 0, 0, 32'h0,       2'b00, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
